div_ctrl: RTL and testbench

//  Sequencer between the EX stage and the 32-cycle radix-2 divider (div).

---
 rtl/div_ctrl_pkg.sv | 13 +
 rtl/div_ctrl_if.sv | 39 +++
 rtl/div_sign_fix.sv | 15 +
 rtl/div_ctrl.sv | 142 ++++++++++++++
 tb/tb_div_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the divider sequencer: widths, timeout default and FSM encodings.
package div_ctrl_pkg;

    localparam int DIV_DATA_W  = 32;
    localparam int DIV_TIMEOUT = 40;

    typedef logic [1:0] div_state_t;

    localparam logic [1:0] DIV_CTRL_IDLE = 2'b00;
    localparam logic [1:0] DIV_CTRL_BUSY = 2'b01;
    localparam logic [1:0] DIV_CTRL_DONE = 2'b10;

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage and divider-side signals of the divide sequencer.
// Handshake: req_i is held by EX until the one-cycle result_valid_o pulse; div_start_o is held
// for the whole divide and div_ready_i is honoured only while it is high; flush_i overrides both.
interface div_ctrl_if
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
);
    logic                  req_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  flush_i;
    logic                  stallreq_o;
    logic [2*DATA_W-1:0]   result_o;
    logic                  result_valid_o;
    logic                  timeout_o;
    logic [DATA_W-1:0]     div_opdata1_o;
    logic [DATA_W-1:0]     div_opdata2_o;
    logic                  div_start_o;
    logic                  div_annul_o;
    logic [2*DATA_W-1:0]   div_result_i;
    logic                  div_ready_i;

    // Sequencer side.
    modport slave (
        input  req_i, signed_i, opdata1_i, opdata2_i, flush_i, div_result_i, div_ready_i,
        output stallreq_o, result_o, result_valid_o, timeout_o,
        output div_opdata1_o, div_opdata2_o, div_start_o, div_annul_o
    );

    // Pipeline plus divider side.
    modport master (
        output req_i, signed_i, opdata1_i, opdata2_i, flush_i, div_result_i, div_ready_i,
        input  stallreq_o, result_o, result_valid_o, timeout_o,
        input  div_opdata1_o, div_opdata2_o, div_start_o, div_annul_o
    );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; used both for operand magnitudes and result sign correction.
module div_sign_fix
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic              neg_i,
    output logic [DATA_W-1:0] y_o
);

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign y_o = neg_i ? (~a_i + 1'b1) : a_i;

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between EX and the radix-2 divider: operand magnitudes, launch/annul,
// pipeline stall, sign correction, divide-by-zero short-circuit and timeout.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W  = DIV_DATA_W,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    div_ctrl_if.slave   bus,
    output div_state_t  state_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    div_state_t          state_q, state_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic                annul;
    logic                tmo;
    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [DATA_W-1:0]   quot_fix, rem_fix;
    logic                div_zero;
    logic                timeout_hit;

    div_sign_fix #(.DATA_W(DATA_W)) u_abs1 (
        .a_i   (bus.opdata1_i),
        .neg_i (bus.signed_i & bus.opdata1_i[DATA_W-1]),
        .y_o   (op1_abs)
    );

    div_sign_fix #(.DATA_W(DATA_W)) u_abs2 (
        .a_i   (bus.opdata2_i),
        .neg_i (bus.signed_i & bus.opdata2_i[DATA_W-1]),
        .y_o   (op2_abs)
    );

    div_sign_fix #(.DATA_W(DATA_W)) u_quot (
        .a_i   (bus.div_result_i[DATA_W-1:0]),
        .neg_i (negq_q),
        .y_o   (quot_fix)
    );

    div_sign_fix #(.DATA_W(DATA_W)) u_rem (
        .a_i   (bus.div_result_i[2*DATA_W-1:DATA_W]),
        .neg_i (negr_q),
        .y_o   (rem_fix)
    );

    assign div_zero = (bus.opdata2_i == '0);
    // cnt_q is 0 in the first BUSY cycle, so the abort lands on BUSY cycle TIMEOUT.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        annul    = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            DIV_CTRL_IDLE: begin
                if (bus.req_i && !bus.flush_i) begin
                    op1_d  = op1_abs;
                    op2_d  = op2_abs;
                    negq_d = bus.signed_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                    negr_d = bus.signed_i & bus.opdata1_i[DATA_W-1];
                    cnt_d  = '0;
                    if (div_zero) begin
                        result_d = '0;
                        state_d  = DIV_CTRL_DONE;
                    end else begin
                        state_d  = DIV_CTRL_BUSY;
                    end
                end
            end
            DIV_CTRL_BUSY: begin
                // Flush beats a same-cycle ready; a late ready on the abort cycle still wins.
                if (bus.flush_i) begin
                    annul   = 1'b1;
                    state_d = DIV_CTRL_IDLE;
                end else if (bus.div_ready_i) begin
                    result_d = {rem_fix, quot_fix};
                    state_d  = DIV_CTRL_DONE;
                end else if (timeout_hit) begin
                    annul    = 1'b1;
                    tmo      = 1'b1;
                    result_d = '0;
                    state_d  = DIV_CTRL_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV_CTRL_DONE: begin
                state_d = DIV_CTRL_IDLE;
            end
            default: begin
                state_d = DIV_CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DIV_CTRL_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.stallreq_o     = bus.req_i & ~bus.flush_i & (state_q != DIV_CTRL_DONE);
    assign bus.result_o       = result_q;
    assign bus.result_valid_o = (state_q == DIV_CTRL_DONE);
    assign bus.timeout_o      = tmo;
    assign bus.div_opdata1_o  = op1_q;
    assign bus.div_opdata2_o  = op2_q;
    assign bus.div_start_o    = (state_q == DIV_CTRL_BUSY);
    assign bus.div_annul_o    = annul;
    assign state_o            = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a 32-cycle stub divider and a scoreboard of expected results.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    div_state_t dbg_state;
    logic       stub_never = 1'b0;
    int         stub_cnt;

    logic [63:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    div_ctrl_if #(.DATA_W(W)) bus ();

    div_ctrl #(.DATA_W(W), .TIMEOUT(40)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // Stub divider: answers on the 32nd cycle of div_start_o unless told to stay silent.
    always @(posedge clk or negedge rst) begin
        if (!rst) stub_cnt <= 0;
        else if (!bus.div_start_o) stub_cnt <= 0;
        else stub_cnt <= stub_cnt + 1;
    end

    always_comb begin
        bus.div_ready_i = bus.div_start_o && !stub_never && (stub_cnt == 31);
        if (bus.div_opdata2_o != 0)
            bus.div_result_i = {bus.div_opdata1_o % bus.div_opdata2_o, bus.div_opdata1_o / bus.div_opdata2_o};
        else
            bus.div_result_i = '0;
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint la, lb, q, r;
        if (b == 0) return 64'd0;
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] exp);
        @(posedge clk); #1;
        bus.req_i     = 1'b1;
        bus.signed_i  = s;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        exp_q.push_back(exp);
    endtask

    task automatic release_req();
        @(posedge clk); #1;
        bus.req_i = 1'b0;
    endtask

    // Cycle 1 is the first cycle with req_i high; cyc stays 0 if no valid arrives.
    task automatic wait_valid(input int limit, output int cyc, output int stall_cnt,
                              output int start_cnt, output logic stall_v, output logic [63:0] res);
        cyc = 0; stall_cnt = 0; start_cnt = 0; stall_v = 1'b0; res = '0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.div_start_o) start_cnt++;
            if (bus.result_valid_o) begin
                cyc = i; res = bus.result_o; stall_v = bus.stallreq_o;
                break;
            end
            if (bus.stallreq_o) stall_cnt++;
        end
    endtask

    task automatic test_reset();
        bus.req_i = 1'b0; bus.signed_i = 1'b0; bus.opdata1_i = '0; bus.opdata2_i = '0; bus.flush_i = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({bus.stallreq_o, bus.result_valid_o, bus.timeout_o, bus.div_start_o, bus.div_annul_o} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {bus.stallreq_o, bus.result_valid_o, bus.timeout_o, bus.div_start_o, bus.div_annul_o});
        else n_pass++;
        n_total++;
        if (bus.result_o !== 64'd0) $display("FAIL reset_result got %h want 0", bus.result_o); else n_pass++;
        n_total++;
        if ({bus.div_opdata1_o, bus.div_opdata2_o} !== 64'd0)
            $display("FAIL reset_opdata got %h want 0", {bus.div_opdata1_o, bus.div_opdata2_o});
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (dbg_state !== DIV_CTRL_IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, DIV_CTRL_IDLE); else n_pass++;
    endtask

    task automatic test_divu_basic();
        int cyc, sc, stc; logic sv; logic [63:0] res, exp;
        issue(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        wait_valid(60, cyc, sc, stc, sv, res);
        exp = exp_q.pop_front();
        n_total++; if (res !== exp) $display("FAIL divu_result got %h want %h", res, exp); else n_pass++;
        n_total++; if (cyc !== 34) $display("FAIL divu_latency got %0d want 34", cyc); else n_pass++;
        n_total++; if (sc !== 33) $display("FAIL divu_stall_cycles got %0d want 33", sc); else n_pass++;
        n_total++; if (stc !== 32) $display("FAIL divu_start_cycles got %0d want 32", stc); else n_pass++;
        n_total++; if (sv !== 1'b0) $display("FAIL divu_stall_in_done got %b want 0", sv); else n_pass++;
        n_total++; if (bus.div_opdata1_o !== 32'd100) $display("FAIL divu_opdata1 got %h want 64", bus.div_opdata1_o); else n_pass++;
        release_req();
        @(negedge clk);
        n_total++; if (bus.result_valid_o !== 1'b0) $display("FAIL divu_valid_pulse got %b want 0", bus.result_valid_o); else n_pass++;
        n_total++; if (dbg_state !== DIV_CTRL_IDLE) $display("FAIL divu_no_relaunch got %0d want 0", dbg_state); else n_pass++;
    endtask

    task automatic test_signed();
        int cyc, sc, stc; logic sv; logic [63:0] res, exp;
        logic [31:0] a_t[4], b_t[4], m1_t[4], m2_t[4];
        logic [63:0] e_t[4];
        a_t[0] = 32'hFFFF_FFF9; b_t[0] = 32'd2;         e_t[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD}; m1_t[0] = 32'd7;         m2_t[0] = 32'd2;
        a_t[1] = 32'd7;         b_t[1] = 32'hFFFF_FFFE; e_t[1] = {32'd1, 32'hFFFF_FFFD};         m1_t[1] = 32'd7;         m2_t[1] = 32'd2;
        a_t[2] = 32'h8000_0000; b_t[2] = 32'hFFFF_FFFF; e_t[2] = {32'd0, 32'h8000_0000};         m1_t[2] = 32'h8000_0000; m2_t[2] = 32'd1;
        a_t[3] = 32'hFFFF_FFF9; b_t[3] = 32'hFFFF_FFFE; e_t[3] = {32'hFFFF_FFFF, 32'd3};         m1_t[3] = 32'd7;         m2_t[3] = 32'd2;
        for (int k = 0; k < 4; k++) begin
            issue(a_t[k], b_t[k], 1'b1, e_t[k]);
            wait_valid(60, cyc, sc, stc, sv, res);
            exp = exp_q.pop_front();
            n_total++; if (res !== exp) $display("FAIL div_signed_%0d_result got %h want %h", k, res, exp); else n_pass++;
            n_total++; if (cyc !== 34) $display("FAIL div_signed_%0d_latency got %0d want 34", k, cyc); else n_pass++;
            n_total++;
            if ({bus.div_opdata1_o, bus.div_opdata2_o} !== {m1_t[k], m2_t[k]})
                $display("FAIL div_signed_%0d_magnitudes got %h want %h", k, {bus.div_opdata1_o, bus.div_opdata2_o}, {m1_t[k], m2_t[k]});
            else n_pass++;
            release_req();
        end
    endtask

    task automatic test_div_zero();
        int cyc, sc, stc; logic sv; logic [63:0] res, exp;
        logic [31:0] a_t[2];
        logic s_t[2];
        a_t[0] = 32'd123;       s_t[0] = 1'b0;
        a_t[1] = 32'hFFFF_FFFB; s_t[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue(a_t[k], 32'd0, s_t[k], 64'd0);
            wait_valid(10, cyc, sc, stc, sv, res);
            exp = exp_q.pop_front();
            n_total++; if (res !== exp) $display("FAIL divzero_%0d_result got %h want %h", k, res, exp); else n_pass++;
            n_total++; if (cyc !== 2) $display("FAIL divzero_%0d_latency got %0d want 2", k, cyc); else n_pass++;
            n_total++; if (stc !== 0) $display("FAIL divzero_%0d_start got %0d want 0", k, stc); else n_pass++;
            release_req();
        end
    endtask

    task automatic test_flush();
        int cyc, sc, stc, nvalid; logic sv; logic [63:0] res, exp;
        @(posedge clk); #1;
        bus.req_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        repeat (10) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(negedge clk);
        n_total++; if (bus.div_annul_o !== 1'b1) $display("FAIL flush_annul got %b want 1", bus.div_annul_o); else n_pass++;
        n_total++; if (bus.stallreq_o !== 1'b0) $display("FAIL flush_stall got %b want 0", bus.stallreq_o); else n_pass++;
        @(posedge clk); #1;
        bus.flush_i = 1'b0; bus.req_i = 1'b0;
        @(negedge clk);
        n_total++;
        if ({dbg_state, bus.div_annul_o, bus.div_start_o} !== {DIV_CTRL_IDLE, 2'b00})
            $display("FAIL flush_idle got %b want %b", {dbg_state, bus.div_annul_o, bus.div_start_o}, {DIV_CTRL_IDLE, 2'b00});
        else n_pass++;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.result_valid_o) nvalid++;
        end
        n_total++; if (nvalid !== 0) $display("FAIL flush_no_valid got %0d want 0", nvalid); else n_pass++;
        issue(32'd9, 32'd3, 1'b0, {32'd0, 32'd3});
        wait_valid(60, cyc, sc, stc, sv, res);
        exp = exp_q.pop_front();
        n_total++; if (res !== exp) $display("FAIL flush_next_result got %h want %h", res, exp); else n_pass++;
        n_total++; if (cyc !== 34) $display("FAIL flush_next_latency got %0d want 34", cyc); else n_pass++;
        release_req();
    endtask

    task automatic test_timeout();
        int tcyc, vcyc, ntmo; logic annul_t; logic [63:0] res, exp;
        tcyc = 0; vcyc = 0; ntmo = 0; annul_t = 1'b0; res = '1;
        stub_never = 1'b1;
        issue(32'd5, 32'd1, 1'b0, 64'd0);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.timeout_o) begin
                ntmo++;
                if (tcyc == 0) begin tcyc = i; annul_t = bus.div_annul_o; end
            end
            if (bus.result_valid_o) begin vcyc = i; res = bus.result_o; break; end
        end
        exp = exp_q.pop_front();
        n_total++; if (tcyc !== 41) $display("FAIL timeout_cycle got %0d want 41", tcyc); else n_pass++;
        n_total++; if (annul_t !== 1'b1) $display("FAIL timeout_annul got %b want 1", annul_t); else n_pass++;
        n_total++; if (ntmo !== 1) $display("FAIL timeout_pulses got %0d want 1", ntmo); else n_pass++;
        n_total++; if (vcyc !== 42) $display("FAIL timeout_valid_cycle got %0d want 42", vcyc); else n_pass++;
        n_total++; if (res !== exp) $display("FAIL timeout_result got %h want %h", res, exp); else n_pass++;
        release_req();
        stub_never = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc, sc, stc; logic sv; logic [63:0] res, exp;
        logic [31:0] a, b; logic s;
        for (int k = 0; k < 5; k++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 100)) : $urandom;
            if (b == 0) b = 32'd1;
            s = 1'($urandom_range(0, 1));
            issue(a, b, s, model(a, b, s));
            wait_valid(60, cyc, sc, stc, sv, res);
            exp = exp_q.pop_front();
            n_total++;
            if (res !== exp) $display("FAIL b2b_%0d_result a=%h b=%h s=%b got %h want %h", k, a, b, s, res, exp);
            else n_pass++;
            release_req();
        end
    endtask

    task automatic test_reset_mid_busy();
        int cyc, sc, stc; logic sv; logic [63:0] res, exp;
        @(posedge clk); #1;
        bus.req_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd10;
        repeat (5) @(posedge clk);
        #2;
        bus.req_i = 1'b0;
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.stallreq_o, bus.result_valid_o, bus.timeout_o, bus.div_start_o, bus.div_annul_o} !== 5'b0)
            $display("FAIL rstbusy_ctrl got %b want 00000", {bus.stallreq_o, bus.result_valid_o, bus.timeout_o, bus.div_start_o, bus.div_annul_o});
        else n_pass++;
        n_total++;
        if ({bus.result_o, bus.div_opdata1_o, bus.div_opdata2_o} !== 128'd0)
            $display("FAIL rstbusy_data got %h want 0", {bus.result_o, bus.div_opdata1_o, bus.div_opdata2_o});
        else n_pass++;
        n_total++; if (dbg_state !== DIV_CTRL_IDLE) $display("FAIL rstbusy_state got %0d want 0", dbg_state); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        issue(32'd9, 32'd3, 1'b0, {32'd0, 32'd3});
        wait_valid(60, cyc, sc, stc, sv, res);
        exp = exp_q.pop_front();
        n_total++; if (res !== exp) $display("FAIL rstbusy_next_result got %h want %h", res, exp); else n_pass++;
        release_req();
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_flush();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
